object_fetcher: RTL
===================

// Module: object_fetcher
// PURPOSE
//  Reads the per-frame object list from the object buffer RAM and broadcasts one object at a time to all UNITS.
//  - Advances on each rising edge of next_task from task_dispatcher.
//  - Raises read_end once the final object has been issued; task_dispatcher gates tasks_complete with it.
//  - Sits between the object buffer RAM and the unit array.
// PARAMETERS
//  UNITS       16  number of units (fan-out documentation only; object bus is broadcast)
//  OBJ_WIDTH   96  bits per object word
//  ADDR_WIDTH  10  object RAM address width; max objects per frame = 2**ADDR_WIDTH
// PORTS
//  clock         in   1              single clock; all logic rising-edge
//  reset_n       in   1              asynchronous, active-low reset
//  frame_start   in   1              1-cycle pulse: begin new frame, latch object_count
//  object_count  in   ADDR_WIDTH+1   objects in frame; sampled only with frame_start
//  next_task     in   1              from task_dispatcher (registered &task_complete), level
//  mem_rd_en     out  1              RAM read strobe
//  mem_addr      out  ADDR_WIDTH     RAM read address
//  mem_rd_data   in   OBJ_WIDTH      RAM data, valid exactly 1 cycle after mem_rd_en
//  object_data   out  OBJ_WIDTH      broadcast object; held stable until next issue
//  object_valid  out  1              1-cycle pulse: object_data is new
//  read_end      out  1              level: all objects of frame issued
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, next_task edge register 0.
//  FSM states and transitions:
//   - IDLE:  frame_start -> FETCH (or DONE if count=0).
//   - FETCH: mem_rd_en=1, mem_addr=idx -> WAIT.
//   - WAIT:  -> ISSUE.
//   - ISSUE: object_data<=mem_rd_data, object_valid=1, idx++ -> HOLD (or DONE if idx==count).
//   - HOLD:  rising edge of next_task (next_task & ~next_task_q) -> FETCH.
//   - DONE:  read_end=1; next_task ignored; frame_start -> restart.
//  Latency:
//   - frame_start in cycle N -> mem_rd_en in N+1 -> object_valid in N+3.
//   - next_task rise sampled in N -> object_valid in N+3.
//  Only rising edges advance:
//   - next_task stays high for some cycles after object_valid until units drop task_complete.
//   - A level held continuously never issues twice.
//  read_end:
//   - Asserts the cycle after the last object_valid.
//   - Held until the next frame_start, then cleared in the following cycle.
//  object_count:
//   - 0 -> read_end=1 the cycle after frame_start; no RAM read, no object_valid.
//   - Values > 2**ADDR_WIDTH saturate to 2**ADDR_WIDTH.
//   - idx is ADDR_WIDTH+1 bits; mem_addr = idx[ADDR_WIDTH-1:0]; no wrap within a frame.
//  frame_start in any non-IDLE state:
//   - Aborts the current frame: idx<=0, count relatched, read_end<=0, -> FETCH.
//   - Any read in flight is discarded; no object_valid from the old frame.
//  frame_start and a next_task edge in the same cycle: frame_start wins.
//  reset_n low mid-frame: immediate return to reset values; no partial object_valid.
// CONFIGURATION
//  OBJECT_FETCHER_PREFETCH_EN defined:
//   - After each ISSUE, the next object (if any) is read into a shadow register while in HOLD.
//   - A next_task rise sampled in N -> object_valid in N+1.
//   - If the rise arrives before the prefetch data returns, issue as soon as it lands (≤N+3).
//   - frame_start invalidates the shadow register.
//  Undefined: no shadow register, no RAM reads while in HOLD, latency as above.
// TESTING
//  - count=3, RAM[0..2]=A,B,C; frame_start; pulse next_task after each issue
//    -> object_valid with A,B,C, mem_addr 0,1,2; read_end 1 cycle after C.
//  - count=0; frame_start -> read_end=1 in N+1; mem_rd_en and object_valid never asserted.
//  - count=2; hold next_task high for 10 cycles after first issue
//    -> only A issued; B only after next_task falls and rises again.
//  - count=4; frame_start again while in HOLD after the 2nd object
//    -> idx restarts, next object_valid carries RAM[0], read_end stays 0.
//  - reset_n low during WAIT -> all outputs 0 asynchronously; after release, frame_start restarts cleanly.
//  - PREFETCH_EN: next_task rise at N after prefetch landed -> object_valid at N+1;
//    undefined -> object_valid at N+3.

Source files
------------

// File: rtl/object_fetcher.sv
// object_fetcher: reads the per-frame object list from the object buffer RAM and
// broadcasts one object at a time to the unit array. Each rising edge of
// next_task advances to the next object. read_end flags that the frame is done.
// Optional feature macro: OBJECT_FETCHER_PREFETCH_EN. When it is defined, the next
// object is read into a shadow register while waiting in HOLD, so a next_task
// rise issues it on the following cycle.
module object_fetcher #(
    parameter int UNITS      = 16,
    parameter int OBJ_WIDTH  = 96,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH:0]   object_count,
    input  logic                  next_task,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [OBJ_WIDTH-1:0]  mem_rd_data,
    output logic [OBJ_WIDTH-1:0]  object_data,
    output logic                  object_valid,
    output logic                  read_end
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] IDX_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH:0]   r_idx;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_next_task_q;
    logic [OBJ_WIDTH-1:0]  r_object_data;

    logic                  w_rise;
    logic                  w_capture;
    logic [OBJ_WIDTH-1:0]  w_capture_data;
    logic [ADDR_WIDTH:0]   w_count_sat;
    logic                  w_unused_units;

    // UNITS only documents the fan-out; the object bus is a plain broadcast.
    assign w_unused_units = (UNITS > 0);

    // A level on next_task that stays high must never issue twice.
    assign w_rise      = next_task & ~r_next_task_q;
    assign w_count_sat = (object_count > MAX_COUNT) ? MAX_COUNT : object_count;

    assign mem_addr     = r_idx[ADDR_WIDTH-1:0];
    assign object_data  = r_object_data;
    assign object_valid = (r_state == S_ISSUE);
    assign read_end     = (r_state == S_DONE);

`ifdef OBJECT_FETCHER_PREFETCH_EN
    logic                 r_pf_issued;
    logic                 r_pf_rd_q;
    logic                 r_pending;
    logic                 r_shadow_valid;
    logic [OBJ_WIDTH-1:0] r_shadow;
`endif

    // Next-state and RAM/capture control.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        w_state_next   = r_state;
        mem_rd_en      = 1'b0;
        w_capture      = 1'b0;
        w_capture_data = mem_rd_data;
        case (r_state)
            S_IDLE: w_state_next = S_IDLE;
            S_FETCH: begin
                mem_rd_en    = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // RAM data is valid only in this cycle, so it is captured here.
                w_capture    = 1'b1;
                w_state_next = S_ISSUE;
            end
            S_ISSUE: w_state_next = (r_idx == r_count) ? S_DONE : S_HOLD;
            S_HOLD: begin
`ifdef OBJECT_FETCHER_PREFETCH_EN
                mem_rd_en = ~r_pf_issued;
                if ((w_rise || r_pending) && (r_shadow_valid || r_pf_rd_q)) begin
                    w_capture      = 1'b1;
                    w_capture_data = r_shadow_valid ? r_shadow : mem_rd_data;
                    w_state_next   = S_ISSUE;
                end
`else
                if (w_rise) begin
                    w_state_next = S_FETCH;
                end
`endif
            end
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
        // A new frame wins over everything and drops any read still in flight.
        if (frame_start) begin
            w_capture    = 1'b0;
            w_state_next = (w_count_sat == '0) ? S_DONE : S_FETCH;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            r_state <= w_state_next;
        end
    end

    // Object index, latched count, next_task edge register and output data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx         <= '0;
            r_count       <= '0;
            r_next_task_q <= 1'b0;
            // NOTE: the data register is reset as well, because reset must drive every output to 0.
            r_object_data <= '0;
        end else begin
            r_next_task_q <= next_task;
            if (frame_start) begin
                r_idx   <= '0;
                r_count <= w_count_sat;
            end else if (w_capture) begin
                r_idx         <= r_idx + IDX_ONE;
                r_object_data <= w_capture_data;
            end
        end
    end

`ifdef OBJECT_FETCHER_PREFETCH_EN
    // Shadow prefetch: one read per HOLD visit, data parked until the next rise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pf_issued    <= 1'b0;
            r_pf_rd_q      <= 1'b0;
            r_pending      <= 1'b0;
            r_shadow_valid <= 1'b0;
            r_shadow       <= '0;
        end else if (frame_start) begin
            r_pf_issued    <= 1'b0;
            r_pf_rd_q      <= 1'b0;
            r_pending      <= 1'b0;
            r_shadow_valid <= 1'b0;
        end else begin
            r_pf_rd_q <= (r_state == S_HOLD) && mem_rd_en;
            if ((r_state == S_HOLD) && mem_rd_en) begin
                r_pf_issued <= 1'b1;
            end else if (r_state != S_HOLD) begin
                r_pf_issued <= 1'b0;
            end
            if (w_capture) begin
                r_shadow_valid <= 1'b0;
            end else if (r_pf_rd_q) begin
                r_shadow       <= mem_rd_data;
                r_shadow_valid <= 1'b1;
            end
            if (w_capture) begin
                r_pending <= 1'b0;
            end else if ((r_state == S_HOLD) && w_rise) begin
                r_pending <= 1'b1;
            end
        end
    end
`endif

endmodule
